acq_ctrl: RTL

ACQ_CTRL -- requirements
Module: acq_ctrl

---
 rtl/osc_pkg.sv | 24 ++
 rtl/sample_counter.sv | 30 +++
 rtl/acq_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/osc_pkg.sv
// Shared types and defaults for the oscilloscope acquisition path.
// Used by the capture controller, write-address and trigger blocks.
package osc_pkg;

  localparam int DEPTH_DEF = 1024;
  localparam int AW_DEF    = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ARMED,
    S_POST,
    S_HOLD
  } state_t;

  localparam logic [1:0] MODE_AUTO   = 2'd0;
  localparam logic [1:0] MODE_NORMAL = 2'd1;
  localparam logic [1:0] MODE_SINGLE = 2'd2;

  function automatic logic is_cont(input logic [1:0] m);
    return (m == MODE_AUTO) || (m == MODE_NORMAL);
  endfunction

endpackage

// File: rtl/sample_counter.sv
// Sample counter with clear, enable and terminal-count compare.
// A clear coincident with enable starts the count at one.
module sample_counter #(
  parameter int CW = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic [CW-1:0] i_tc,
  output logic          o_at_tc,
  output logic          o_next_tc
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= {{(CW-1){1'b0}}, i_en};
    end else if (i_en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_at_tc   = (r_cnt == i_tc);
  assign o_next_tc = ((r_cnt + CW'(1)) == i_tc);

endmodule

// File: rtl/acq_ctrl.sv
// Capture-buffer acquisition controller: pre-trigger fill, trigger
// wait with auto timeout, post-trigger fill and frame hold.
module acq_ctrl
  import osc_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int AW      = AW_DEF,
  parameter int AUTO_TO = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sample_en,
  input  logic          trigger,
  input  logic [1:0]    run_mode,
  input  logic          arm,
  input  logic [AW-1:0] pretrig,
  input  logic          disp_done,
  output logic          wren,
  output logic [AW-1:0] wraddress,
  output logic          rst_trig,
  output logic          frame_ready,
  output logic [AW-1:0] trig_addr,
  output logic          auto_trig
);

  localparam int TW = $clog2(AUTO_TO + 1);
  localparam int CW = (AW + 1 > TW) ? AW + 1 : TW;

  state_t        r_state;
  logic [1:0]    r_mode;
  logic [AW-1:0] r_pre;
  logic [AW-1:0] r_wa;
  logic [AW-1:0] r_taddr;
  logic          r_rst_trig;
  logic          r_ready;
  logic          r_auto;

  logic          w_clr;
  logic          w_cen;
  logic [CW-1:0] w_tc;
  logic [CW-1:0] w_post_len;
  logic          w_at_tc;
  logic          w_next_tc;
  logic          w_pre_zero;
  logic          w_pre_done;
  logic          w_post_done;
  logic          w_trig_ev;
  logic          w_one_post;

  assign w_pre_zero = (r_pre == '0);
  assign w_post_len = CW'(DEPTH) - CW'(r_pre);
  assign w_one_post = (w_post_len == CW'(1));

  // A zero pre-trigger depth skips PRE without writing.
  assign wren = sample_en &
    (((r_state == S_PRE) & ~w_pre_zero) |
     (r_state == S_ARMED) |
     (r_state == S_POST));

  assign w_pre_done  = w_pre_zero | (wren & w_next_tc);
  assign w_post_done = wren & w_next_tc;
  assign w_trig_ev   = trigger |
    ((r_mode == MODE_AUTO) & w_at_tc & sample_en);

  always_comb begin
    w_tc = '0;
    unique case (r_state)
      S_PRE:   w_tc = CW'(r_pre);
      S_ARMED: w_tc = CW'(AUTO_TO);
      S_POST:  w_tc = w_post_len;
      default: w_tc = '0;
    endcase
  end

  // One counter serves PRE, the ARMED timeout and POST in turn.
  always_comb begin
    w_clr = 1'b0;
    w_cen = 1'b0;
    unique case (r_state)
      S_PRE: begin
        w_cen = wren & ~w_pre_done;
        w_clr = w_pre_done;
      end
      S_ARMED: begin
        w_cen = sample_en & ~w_at_tc;
        if (w_trig_ev) begin
          w_clr = 1'b1;
          w_cen = sample_en;
        end
      end
      S_POST: begin
        w_cen = wren;
        w_clr = w_post_done;
      end
      default: w_clr = 1'b1;
    endcase
  end

  sample_counter #(.CW(CW)) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_clr),
    .i_en      (w_cen),
    .i_tc      (w_tc),
    .o_at_tc   (w_at_tc),
    .o_next_tc (w_next_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_mode     <= MODE_AUTO;
      r_pre      <= '0;
      r_wa       <= '0;
      r_taddr    <= '0;
      r_rst_trig <= 1'b0;
      r_ready    <= 1'b0;
      r_auto     <= 1'b0;
    end else begin
      r_rst_trig <= 1'b0;
      if (wren) r_wa <= r_wa + 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (arm || is_cont(run_mode)) begin
            r_state    <= S_PRE;
            r_mode     <= run_mode;
            r_pre      <= pretrig;
            r_rst_trig <= 1'b1;
          end
        end
        S_PRE: begin
          if (w_pre_done) r_state <= S_ARMED;
        end
        S_ARMED: begin
          if (w_trig_ev) begin
            r_taddr <= r_wa;
            r_auto  <= ~trigger;
            // A one-sample frame completes on the trigger write.
            if (sample_en && w_one_post) begin
              r_state <= S_HOLD;
              r_ready <= 1'b1;
            end else begin
              r_state <= S_POST;
            end
          end
        end
        S_POST: begin
          if (w_post_done) begin
            r_state <= S_HOLD;
            r_ready <= 1'b1;
          end
        end
        S_HOLD: begin
          if (disp_done) begin
            r_ready <= 1'b0;
            if (is_cont(run_mode)) begin
              r_state    <= S_PRE;
              r_mode     <= run_mode;
              r_pre      <= pretrig;
              r_rst_trig <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wraddress   = r_wa;
  assign rst_trig    = r_rst_trig;
  assign frame_ready = r_ready;
  assign trig_addr   = r_taddr;
  assign auto_trig   = r_auto;

endmodule
